fp_adder_arbiter: RTL

FP_ADDER_ARBITER -- requirements
Module: fp_adder_arbiter

---
 rtl/fp_adder_arbiter_if.sv | 39 +++
 rtl/fp_adder_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fp_adder_arbiter_if.sv
// Bus between the shared-FP-adder arbiter and its requesters/adder.
// slave is the arbiter's view; master is the environment's view.
interface fp_adder_arbiter_if #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    parameter int N_REQ      = 4
);
    localparam int FP_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int ID_W     = $clog2(N_REQ);

    logic [N_REQ-1:0]          req_valid_i;
    logic [N_REQ-1:0]          req_ready_o;
    logic [N_REQ*FP_WIDTH-1:0] req_a_i;
    logic [N_REQ*FP_WIDTH-1:0] req_b_i;
    logic [FP_WIDTH-1:0]       add_a_o;
    logic [FP_WIDTH-1:0]       add_b_o;
    logic                      add_valid_o;
    logic [FP_WIDTH-1:0]       add_sum_i;
    logic                      add_valid_i;
    logic [FP_WIDTH-1:0]       res_o;
    logic [N_REQ-1:0]          res_valid_o;
    logic [ID_W-1:0]           res_id_o;
    logic                      drain_i;
    logic                      drain_done_o;
    logic [4:0]                inflight_o;
    logic                      err_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, add_sum_i, add_valid_i, drain_i,
        output req_ready_o, add_a_o, add_b_o, add_valid_o, res_o, res_valid_o,
               res_id_o, drain_done_o, inflight_o, err_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, add_sum_i, add_valid_i, drain_i,
        input  req_ready_o, add_a_o, add_b_o, add_valid_o, res_o, res_valid_o,
               res_id_o, drain_done_o, inflight_o, err_o
    );
endinterface

// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP adder among N_REQ requesters,
// with an ID tag pipeline that routes each sum back to its owner.
module fp_adder_arbiter #(
    parameter int EXP_WIDTH   = 8,
    parameter int FRAC_WIDTH  = 23,
    parameter int N_REQ       = 4,
    parameter int ADD_LATENCY = 7
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    fp_adder_arbiter_if.slave  bus
);
    localparam int FP_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int ID_W     = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_e;

    state_e              state_q;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [4:0]          inflight_q;
    logic                err_q, drain_done_q;
    logic                add_valid_q;
    logic [FP_WIDTH-1:0] add_a_q, add_b_q;
    logic [ID_W-1:0]     add_id_q;
    logic                tag_vld_q [ADD_LATENCY];
    logic [ID_W-1:0]     tag_id_q  [ADD_LATENCY];
    logic [FP_WIDTH-1:0] res_q;
    logic [N_REQ-1:0]    res_valid_q;
    logic [ID_W-1:0]     res_id_q;

    logic [ID_W-1:0]     gnt_id, cand;
    logic                gnt_found, hs, hit, mismatch, res_any;
    int                  idx, nxt;

    // Search upward from rr_ptr with wrap; the first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx  = (int'(rr_ptr_q) + i) % N_REQ;
            cand = idx[ID_W-1:0];
            if (!gnt_found && bus.req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
        nxt      = int'(gnt_id) + 1;
        rr_ptr_d = (nxt == N_REQ) ? '0 : nxt[ID_W-1:0];
    end

    // No grants while held in reset or once a drain has been requested.
    assign hs       = rst_ni && (state_q == RUN) && !bus.drain_i && gnt_found;
    assign bus.req_ready_o = hs ? (ONE << gnt_id) : '0;

    assign hit      = bus.add_valid_i &  tag_vld_q[ADD_LATENCY-1];
    assign mismatch = bus.add_valid_i ^  tag_vld_q[ADD_LATENCY-1];
    assign res_any  = |res_valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            add_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_id_q    <= '0;
            res_q       <= '0;
            res_valid_q <= '0;
            res_id_q    <= '0;
            for (int i = 0; i < ADD_LATENCY; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_id_q[i]  <= '0;
            end
        end else begin
            add_valid_q <= hs;
            if (hs) begin
                add_a_q  <= bus.req_a_i[int'(gnt_id)*FP_WIDTH +: FP_WIDTH];
                add_b_q  <= bus.req_b_i[int'(gnt_id)*FP_WIDTH +: FP_WIDTH];
                add_id_q <= gnt_id;
            end
            // Tag entry follows the issue strobe so its tail meets add_valid_i.
            tag_vld_q[0] <= add_valid_q;
            tag_id_q[0]  <= add_id_q;
            for (int i = 1; i < ADD_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
            res_valid_q <= hit ? (ONE << tag_id_q[ADD_LATENCY-1]) : '0;
            if (hit) begin
                res_q    <= bus.add_sum_i;
                res_id_q <= tag_id_q[ADD_LATENCY-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RUN;
            rr_ptr_q     <= '0;
            inflight_q   <= '0;
            err_q        <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            if (hs) rr_ptr_q <= rr_ptr_d;
            if (mismatch) err_q <= 1'b1;
            unique case ({hs, res_any})
                2'b10:   inflight_q <= inflight_q + 5'd1;
                2'b01:   inflight_q <= inflight_q - 5'd1;
                default: inflight_q <= inflight_q;
            endcase
            unique case (state_q)
                RUN: if (bus.drain_i) state_q <= DRAIN;
                DRAIN: if (inflight_q == 5'd0 && !bus.drain_i) begin
                    state_q      <= IDLE;
                    drain_done_q <= 1'b1;
                end
                IDLE: if (!bus.drain_i) begin
                    state_q      <= RUN;
                    drain_done_q <= 1'b0;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.add_a_o      = add_a_q;
    assign bus.add_b_o      = add_b_q;
    assign bus.add_valid_o  = add_valid_q;
    assign bus.res_o        = res_q;
    assign bus.res_valid_o  = res_valid_q;
    assign bus.res_id_o     = res_id_q;
    assign bus.drain_done_o = drain_done_q;
    assign bus.inflight_o   = inflight_q;
    assign bus.err_o        = err_q;
endmodule
